packet_send_module: RTL and testbench
=====================================

Name: packet_send_module

Overview:
- Per-port packet generator that drives one ingress port of the N×N shared-cache switch (top_nxn) with a framed packet.
- On a start pulse it latches destination, priority and length.
- It then emits: an SOP strobe, one header word, `length` payload words, an EOP strobe, and finally a done pulse.
- One instance exists per switch port; the wr_* outputs feed the switch's wr_sop/wr_eop/wr_vld/wr_data slices.

Parameters:
- PORT_NUB_TOTAL, 8: number of switch ports; WIDTH_SEL = clog2(PORT_NUB_TOTAL) = 3.
- DATA_WIDTH, 32: data word width.
- PRIORITY, 8: number of priority levels; WIDTH_PRIORITY = clog2(PRIORITY) = 3.
- DATA_LENGTH_MAX, 1024: maximum payload words; WIDTH_LENGTH = clog2(DATA_LENGTH_MAX) = 10.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to send one packet; sampled only in IDLE.
- dest  in  WIDTH_SEL  destination port number.
- priority  in  WIDTH_PRIORITY  packet priority.
- length  in  WIDTH_LENGTH  payload word count (header excluded).
- done  out  1  one-cycle pulse after the packet completes.
- wr_sop  out  1  start-of-packet strobe.
- wr_eop  out  1  end-of-packet strobe.
- wr_vld  out  1  wr_data valid.
- wr_data  out  DATA_WIDTH  header or payload word.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous): state=IDLE; done, wr_sop, wr_eop, wr_vld = 0; wr_data = 0; latched fields and counter = 0.
- Reset asserted mid-packet aborts immediately. No EOP and no done are emitted. Sending resumes only on a new start after reset is released.
- FSM states: IDLE -> SOP -> HEAD -> DATA -> EOP -> DONE -> IDLE.
- IDLE: on a rising edge with start=1, latch dest/priority/length, clear the payload counter, go to SOP.
- SOP (1 cycle): wr_sop=1, wr_vld=0.
- HEAD (1 cycle): wr_vld=1, wr_data = header word.
  - Header layout: bits [15:0] = {length, priority, dest}, with dest in the LSBs ([2:0]), priority at [5:3], length at [15:6].
  - Bits [31:16] = 0.
  - Header total = 16 + WIDTH_LENGTH + WIDTH_PRIORITY + WIDTH_SEL bits, which equals DATA_WIDTH.
- DATA (`length` cycles): wr_vld=1; payload word k (k = 0..length-1) = k zero-extended to DATA_WIDTH.
  - The counter increments each cycle; leave DATA when k = length-1.
- length = 0: skip DATA; go HEAD -> EOP.
- EOP (1 cycle): wr_eop=1, wr_vld=0.
- DONE (1 cycle): done=1; then IDLE.
- Outputs not named for a state are 0.
- wr_data = 0 whenever wr_vld=0.
- Latency: start sampled at edge E0 gives:
  - wr_sop high after E0
  - header after E1
  - payload after E2..E(length+1)
  - wr_eop after E(length+2)
  - done after E(length+3)
  - Total occupancy is length+4 cycles.
- start while not IDLE is ignored (no queueing). start held high in IDLE launches back-to-back packets, each with a fresh latch.
- Input changes after latching have no effect on the packet in flight.
- No backpressure input: the generator streams unconditionally; the switch's full/error flags are the switch's concern.

Test Plan:
- Reset: hold rst_n=0 for 10 cycles -> all outputs 0, FSM IDLE; start asserted during reset is ignored.
- Basic send: dest=2, priority=1, length=23 ->
  - sop pulse 1 cycle after start
  - header 0x000005CA (length 23<<6 | 1<<3 | 2)
  - 23 payload words 0..22 with vld=1
  - eop pulse, then done pulse 27 cycles after start.
- Zero length: dest=1, priority=2, length=0 -> sop, header 0x00000011, eop, done; exactly 1 vld cycle.
- Busy start: second start 5 cycles into a length=16 packet -> ignored; exactly 16 payload words; a single done.
- Mid-packet reset: assert rst_n=0 during DATA -> outputs 0 at once, no eop/done; a new start after release yields a full correct packet.
- Eight instances on top_nxn: sends (0->2,p1,23), (1->2,p1,16), (2->1,p1,17), (3->2,p1,18), (4..7->2,p2,19..22) on consecutive cycles -> each port's wr_* framing is correct and each done fires at start+length+4.

Source files
------------

// File: rtl/packet_send_module.sv
// Per-port packet generator for one ingress port of the NxN shared-cache switch.
// A start pulse in idle latches destination, priority and length. The block then
// emits, in order:
//   - an SOP strobe,
//   - one header word,
//   - `length` payload words,
//   - an EOP strobe,
//   - a done pulse.
// All outputs are registered. Each output register is loaded from the next state,
// so every output is visible in the same cycle as the state it belongs to.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   start_i     request to send one packet (sampled only in idle)
//   dest_i      destination port number
//   priority_i  packet priority
//   length_i    payload word count (header excluded)
//   done_o      one-cycle pulse after the packet completes
//   wr_sop_o    start-of-packet strobe
//   wr_eop_o    end-of-packet strobe
//   wr_vld_o    wr_data_o valid
//   wr_data_o   header or payload word
module packet_send_module #(
  parameter int unsigned PortNubTotal  = 8,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned Priority      = 8,
  parameter int unsigned DataLengthMax = 1024,
  localparam int unsigned WidthSel      = $clog2(PortNubTotal),
  localparam int unsigned WidthPriority = $clog2(Priority),
  localparam int unsigned WidthLength   = $clog2(DataLengthMax)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [WidthSel-1:0]      dest_i,
  input  logic [WidthPriority-1:0] priority_i,
  input  logic [WidthLength-1:0]   length_i,
  output logic                     done_o,
  output logic                     wr_sop_o,
  output logic                     wr_eop_o,
  output logic                     wr_vld_o,
  output logic [DataWidth-1:0]     wr_data_o
);

  typedef enum logic [2:0] {StIdle, StSop, StHead, StData, StEop, StDone} state_e;

  state_e                   state_q, state_d;
  logic [WidthSel-1:0]      dest_q, dest_d;
  logic [WidthPriority-1:0] prio_q, prio_d;
  logic [WidthLength-1:0]   len_q, len_d;
  logic [WidthLength-1:0]   cnt_q, cnt_d;

  logic                 done_d, sop_d, eop_d, vld_d;
  logic [DataWidth-1:0] data_d;

  // State, latched fields and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      dest_q    <= '0;
      prio_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      done_o    <= 1'b0;
      wr_sop_o  <= 1'b0;
      wr_eop_o  <= 1'b0;
      wr_vld_o  <= 1'b0;
      wr_data_o <= '0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      prio_q    <= prio_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      done_o    <= done_d;
      wr_sop_o  <= sop_d;
      wr_eop_o  <= eop_d;
      wr_vld_o  <= vld_d;
      wr_data_o <= data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    prio_d  = prio_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          dest_d  = dest_i;
          prio_d  = priority_i;
          len_d   = length_i;
          cnt_d   = '0;
          state_d = StSop;
        end
      end
      StSop:  state_d = StHead;
      StHead: state_d = (len_q == '0) ? StEop : StData;
      StData: begin
        // cnt_q is the payload index currently on the bus.
        if (cnt_q == len_q - WidthLength'(1)) begin
          state_d = StEop;
        end else begin
          cnt_d = cnt_q + WidthLength'(1);
        end
      end
      StEop:  state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state, so the output registers line up with state_q.
  always_comb begin
    done_d = 1'b0;
    sop_d  = 1'b0;
    eop_d  = 1'b0;
    vld_d  = 1'b0;
    data_d = '0;
    unique case (state_d)
      StSop: sop_d = 1'b1;
      StHead: begin
        vld_d  = 1'b1;
        data_d = DataWidth'({len_q, prio_q, dest_q});
      end
      StData: begin
        vld_d  = 1'b1;
        data_d = DataWidth'(cnt_d);
      end
      StEop:  eop_d  = 1'b1;
      StDone: done_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_packet_send_module.sv
module tb_packet_send_module;

  typedef struct packed {
    int unsigned cyc;
    logic        sop;
    logic        eop;
    logic        vld;
    logic        done;
    logic [31:0] data;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  dest_i = '0;
  logic [2:0]  priority_i = '0;
  logic [9:0]  length_i = '0;
  logic        done_o, wr_sop_o, wr_eop_o, wr_vld_o;
  logic [31:0] wr_data_o;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];

  packet_send_module dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .dest_i     (dest_i),
    .priority_i (priority_i),
    .length_i   (length_i),
    .done_o     (done_o),
    .wr_sop_o   (wr_sop_o),
    .wr_eop_o   (wr_eop_o),
    .wr_vld_o   (wr_vld_o),
    .wr_data_o  (wr_data_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: any active output cycle is matched against the next expected beat.
  always @(negedge clk_i) begin
    if (rst_ni && (wr_sop_o || wr_eop_o || wr_vld_o || done_o || wr_data_o != '0)) begin
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat cyc=%0d got sop=%b eop=%b vld=%b done=%b data=%h, want none",
                 cyc, wr_sop_o, wr_eop_o, wr_vld_o, done_o, wr_data_o);
      end else begin
        e = sb_q.pop_front();
        if (e.cyc != cyc || e.sop !== wr_sop_o || e.eop !== wr_eop_o || e.vld !== wr_vld_o ||
            e.done !== done_o || e.data !== wr_data_o) begin
          errors++;
          $display("FAIL beat cyc=%0d sop=%b eop=%b vld=%b done=%b data=%h, want cyc=%0d sop=%b eop=%b vld=%b done=%b data=%h",
                   cyc, wr_sop_o, wr_eop_o, wr_vld_o, done_o, wr_data_o,
                   e.cyc, e.sop, e.eop, e.vld, e.done, e.data);
        end
      end
    end
  end

  task automatic push(input int unsigned c, input logic sop, input logic eop, input logic vld,
                      input logic done, input logic [31:0] data);
    exp_t e;
    e.cyc = c; e.sop = sop; e.eop = eop; e.vld = vld; e.done = done; e.data = data;
    sb_q.push_back(e);
  endtask

  // Expected beats of a whole packet whose start is sampled at edge e0.
  task automatic push_pkt(input int unsigned e0, input int unsigned len, input logic [31:0] hdr);
    push(e0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    push(e0 + 1, 1'b0, 1'b0, 1'b1, 1'b0, hdr);
    for (int unsigned k = 0; k < len; k++) push(e0 + 2 + k, 1'b0, 1'b0, 1'b1, 1'b0, k);
    push(e0 + len + 2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    push(e0 + len + 3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk_i);
  endtask

  // Pulse start for one sampling edge, then scramble inputs to prove they were latched.
  task automatic launch(input logic [2:0] d, input logic [2:0] p, input logic [9:0] l,
                        output int unsigned e0);
    @(negedge clk_i); #2;
    start_i = 1'b1; dest_i = d; priority_i = p; length_i = l;
    e0 = cyc + 1;
    @(negedge clk_i); #2;
    start_i = 1'b0; dest_i = ~d; priority_i = ~p; length_i = ~l;
  endtask

  task automatic send(input logic [2:0] d, input logic [2:0] p, input logic [9:0] l,
                      input logic [31:0] hdr);
    int unsigned e0;
    push_pkt(cyc + 1 + 1, l, hdr);  // start sampled at the edge after the next negedge
    launch(d, p, l, e0);
    wait_cyc(e0 + l + 5);
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (wr_sop_o || wr_eop_o || wr_vld_o || done_o || wr_data_o != '0) begin
      errors++;
      $display("FAIL %s sop=%b eop=%b vld=%b done=%b data=%h, want all zero",
               name, wr_sop_o, wr_eop_o, wr_vld_o, done_o, wr_data_o);
    end
  endtask

  initial begin
    int unsigned e0, ea, eb;
    // Reset with start held high: must be ignored.
    start_i = 1'b1; dest_i = 3'd5; length_i = 10'd3;
    repeat (10) @(negedge clk_i);
    check_idle_outputs("reset_outputs");
    start_i = 1'b0;
    #2 rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);

    // Basic send, zero length, length one.
    send(3'd2, 3'd1, 10'd23, 32'h0000_05CA);
    send(3'd1, 3'd2, 10'd0, 32'h0000_0011);
    send(3'd2, 3'd6, 10'd1, 32'h0000_0072);

    // Busy start five cycles into a 16-word packet must be ignored.
    push_pkt(cyc + 2, 16, 32'h0000_0423);
    launch(3'd3, 3'd4, 10'd16, e0);
    wait_cyc(e0 + 5);
    #2 start_i = 1'b1; dest_i = 3'd7; priority_i = 3'd7; length_i = 10'd2;
    @(negedge clk_i); #2 start_i = 1'b0;
    wait_cyc(e0 + 16 + 5);

    // start held high: back-to-back packets, second latches new fields.
    @(negedge clk_i); #2;
    start_i = 1'b1; dest_i = 3'd5; priority_i = 3'd7; length_i = 10'd2;
    ea = cyc + 1;
    eb = ea + 2 + 5;
    push_pkt(ea, 2, 32'h0000_00BD);
    push_pkt(eb, 3, 32'h0000_00C6);
    @(negedge clk_i); #2;
    dest_i = 3'd6; priority_i = 3'd0; length_i = 10'd3;
    wait_cyc(eb);
    #2 start_i = 1'b0;
    wait_cyc(eb + 3 + 5);

    // Mid-packet reset: only beats up to payload word 2 are expected.
    @(negedge clk_i); #2;
    start_i = 1'b1; dest_i = 3'd7; priority_i = 3'd3; length_i = 10'd10;
    e0 = cyc + 1;
    push(e0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    push(e0 + 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_029F);
    for (int unsigned k = 0; k < 3; k++) push(e0 + 2 + k, 1'b0, 1'b0, 1'b1, 1'b0, k);
    @(negedge clk_i); #2 start_i = 1'b0;
    wait_cyc(e0 + 4);
    #2 rst_ni = 1'b0;
    #1 check_idle_outputs("async_reset");
    repeat (3) @(negedge clk_i);
    check_idle_outputs("held_reset");
    #2 rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    send(3'd4, 3'd5, 10'd5, 32'h0000_016C);

    // Maximum length.
    send(3'd0, 3'd0, 10'd1023, 32'h0000_FFC0);

    repeat (5) @(negedge clk_i);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
